// File: rtl/clock_div_counter.sv
// Programmable divide counter: wraps at the latched period, emitting a one-cycle tick and a clk/(2*period) square wave.
// All outputs are registered (one clk from the sampled inputs); period changes are adopted only at a wrap or on load.
module clock_div_counter #(
  parameter int WIDTH       = 19,
  parameter int DIV_DEFAULT = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             clk_out,
  output logic             running
);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_eff;
  logic [WIDTH-1:0] last_cnt;
  logic             at_wrap;

  assign period_eff = (div_val == '0) ? ONE : div_val;
  // period_q is never zero outside of a misconfigured DIV_DEFAULT; keep the subtraction safe anyway.
  assign last_cnt   = (period_q == '0) ? '0 : period_q - ONE;
  assign at_wrap    = (count >= last_cnt);
  assign running    = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= STOP;
      count    <= '0;
      period_q <= DIV_INIT;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      state <= en ? RUN : STOP;
      if (load) begin
        count    <= '0;
        tick     <= 1'b0;
        clk_out  <= 1'b0;
        period_q <= period_eff;
      end else if (en) begin
        if (at_wrap) begin
          count    <= '0;
          tick     <= 1'b1;
          clk_out  <= ~clk_out;
          period_q <= period_eff;
        end else begin
          count <= count + ONE;
          tick  <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_div_counter.sv
// Bench for clock_div_counter: directed scenarios plus randomized traffic against a cycle model.
// Checks sampled 1 time unit after each clk edge; model updated on the same edge.
// No backpressure; stimulus driven directly, failures tallied in fails.
module tb_clock_div_counter;

    localparam int W   = 19;
    localparam int DEF = 12;

    logic         clk;
    logic         reset;
    logic         en;
    logic         load;
    logic [W-1:0] div_val;
    logic [W-1:0] count;
    logic         tick;
    logic         clk_out;
    logic         running;

    int tests = 0;
    int fails = 0;

    int m_count;
    int m_period;
    bit m_tick;
    bit m_clko;
    bit m_run;

    clock_div_counter #(.WIDTH(W), .DIV_DEFAULT(DEF)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .count   (count),
        .tick    (tick),
        .clk_out (clk_out),
        .running (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_count  = 0;
        m_period = DEF;
        m_tick   = 1'b0;
        m_clko   = 1'b0;
        m_run    = 1'b0;
    endtask

    task automatic model_step();
        int eff;
        if (!reset) begin
            model_reset();
            return;
        end
        eff   = (div_val == '0) ? 1 : int'(div_val);
        m_run = en;
        if (load) begin
            m_count  = 0;
            m_tick   = 1'b0;
            m_clko   = 1'b0;
            m_period = eff;
        end else if (en) begin
            m_count = (m_count + 1) % m_period;
            m_tick  = (m_count == 0);
            if (m_tick) begin
                m_clko   = ~m_clko;
                m_period = eff;
            end
        end else begin
            m_tick = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        div_val = '0;
        model_reset();
        #3;
        tests++;
        if ({count, tick, clk_out, running} !== '0) begin
            fails++;
            $display("FAIL reset_initial: got count=%0d tick=%b clk_out=%b running=%b, want all 0",
                     count, tick, clk_out, running);
        end
        en      = 1'b1;
        div_val = W'(5);
        repeat (2) cyc();
        tests++;
        if ({count, tick, clk_out, running} !== '0) begin
            fails++;
            $display("FAIL reset_held: got count=%0d tick=%b clk_out=%b running=%b, want all 0",
                     count, tick, clk_out, running);
        end
    endtask

    task automatic test_default_period();
        int e;
        reset = 1'b1;
        for (int i = 1; i <= DEF; i++) begin
            cyc();
            e = i % DEF;
            tests++;
            if (count !== W'(e) || tick !== (i == DEF)) begin
                fails++;
                $display("FAIL default_period[%0d]: got count=%0d tick=%b, want count=%0d tick=%b",
                         i, count, tick, e, (i == DEF));
            end
        end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            e = k % 5;
            tests++;
            if (count !== W'(e) || tick !== (e == 0)) begin
                fails++;
                $display("FAIL period5[%0d]: got count=%0d tick=%b, want count=%0d tick=%b",
                         k, count, tick, e, (e == 0));
            end
        end
        tests++;
        if ({clk_out, running} !== 2'b11) begin
            fails++;
            $display("FAIL period5_clkout: got clk_out=%b running=%b, want 1 1", clk_out, running);
        end
    endtask

    task automatic test_load();
        int seq [3] = '{1, 2, 0};
        div_val = W'(200);
        load    = 1'b1;
        cyc();
        load = 1'b0;
        repeat (123) cyc();
        tests++;
        if (count !== W'(123)) begin
            fails++;
            $display("FAIL load_precount: got count=%0d, want 123", count);
        end
        div_val = W'(3);
        load    = 1'b1;
        cyc();
        load = 1'b0;
        tests++;
        if ({count, tick, clk_out} !== '0) begin
            fails++;
            $display("FAIL load_clear: got count=%0d tick=%b clk_out=%b, want 0 0 0", count, tick, clk_out);
        end
        for (int j = 0; j < 3; j++) begin
            cyc();
            tests++;
            if (count !== W'(seq[j]) || tick !== (seq[j] == 0)) begin
                fails++;
                $display("FAIL load_seq[%0d]: got count=%0d tick=%b, want count=%0d tick=%b",
                         j, count, tick, seq[j], (seq[j] == 0));
            end
        end
        tests++;
        if (clk_out !== 1'b1) begin
            fails++;
            $display("FAIL load_wrap_clkout: got clk_out=%b, want 1", clk_out);
        end
    endtask

    task automatic test_period_change();
        div_val = W'(4);
        load    = 1'b1;
        cyc();
        load = 1'b0;
        repeat (2) cyc();
        tests++;
        if (count !== W'(2)) begin
            fails++;
            $display("FAIL chg_start: got count=%0d, want 2", count);
        end
        div_val = W'(7);
        cyc();
        tests++;
        if (count !== W'(3) || tick !== 1'b0) begin
            fails++;
            $display("FAIL chg_old_last: got count=%0d tick=%b, want count=3 tick=0", count, tick);
        end
        cyc();
        tests++;
        if (count !== '0 || tick !== 1'b1) begin
            fails++;
            $display("FAIL chg_wrap: got count=%0d tick=%b, want count=0 tick=1", count, tick);
        end
        for (int k = 1; k <= 7; k++) begin
            cyc();
            tests++;
            if (count !== W'(k % 7) || tick !== (k == 7)) begin
                fails++;
                $display("FAIL chg_new[%0d]: got count=%0d tick=%b, want count=%0d tick=%b",
                         k, count, tick, k % 7, (k == 7));
            end
        end
    endtask

    task automatic test_period_one();
        for (int dv = 0; dv <= 1; dv++) begin
            div_val = W'(dv);
            load    = 1'b1;
            cyc();
            load = 1'b0;
            tests++;
            if ({count, tick, clk_out} !== '0) begin
                fails++;
                $display("FAIL p1_load[dv=%0d]: got count=%0d tick=%b clk_out=%b, want 0 0 0",
                         dv, count, tick, clk_out);
            end
            for (int j = 1; j <= 6; j++) begin
                cyc();
                tests++;
                if (count !== '0 || tick !== 1'b1 || clk_out !== 1'(j % 2)) begin
                    fails++;
                    $display("FAIL p1[dv=%0d,%0d]: got count=%0d tick=%b clk_out=%b, want 0 1 %0d",
                             dv, j, count, tick, clk_out, j % 2);
                end
            end
        end
    endtask

    task automatic test_en_hold();
        logic hold;
        int   seq [3] = '{3, 4, 0};
        div_val = W'(5);
        load    = 1'b1;
        cyc();
        load = 1'b0;
        repeat (2) cyc();
        hold = clk_out;
        en   = 1'b0;
        for (int j = 0; j < 10; j++) begin
            cyc();
            tests++;
            if (count !== W'(2) || running !== 1'b0 || tick !== 1'b0 || clk_out !== hold) begin
                fails++;
                $display("FAIL hold[%0d]: got count=%0d running=%b tick=%b clk_out=%b, want 2 0 0 %b",
                         j, count, running, tick, clk_out, hold);
            end
        end
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            tests++;
            if (count !== W'(seq[j]) || tick !== (seq[j] == 0) || running !== 1'b1) begin
                fails++;
                $display("FAIL resume[%0d]: got count=%0d tick=%b running=%b, want %0d %b 1",
                         j, count, tick, running, seq[j], (seq[j] == 0));
            end
        end
    endtask

    task automatic test_async_reset();
        logic prev;
        int   n = 0;
        bit   seen = 1'b0;
        div_val = W'(3);
        load    = 1'b1;
        cyc();
        load = 1'b0;
        repeat (4) cyc();
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({count, tick, clk_out, running} !== '0) begin
            fails++;
            $display("FAIL async_reset: got count=%0d tick=%b clk_out=%b running=%b, want all 0",
                     count, tick, clk_out, running);
        end
        repeat (2) cyc();
        reset = 1'b1;
        for (int i = 1; i <= DEF; i++) cyc();
        tests++;
        if (count !== '0 || tick !== 1'b1 || clk_out !== 1'b1) begin
            fails++;
            $display("FAIL async_first_wrap: got count=%0d tick=%b clk_out=%b, want 0 1 1",
                     count, tick, clk_out);
        end
        for (int i = 1; i <= 50 && !seen; i++) begin
            prev = clk_out;
            cyc();
            if (prev == 1'b0 && clk_out == 1'b1) begin
                seen = 1'b1;
                n    = i;
            end
        end
        tests++;
        if (n != 6) begin
            fails++;
            $display("FAIL async_clkout_period: got %0d cycles, want 6", n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) div_val = W'($urandom_range(0, 9));
            cyc();
            tests++;
            if ({count, tick, clk_out, running} !== {W'(m_count), m_tick, m_clko, m_run}) begin
                fails++;
                $display("FAIL random[%0d]: got count=%0d tick=%b clk_out=%b running=%b, want %0d %b %b %b",
                         i, count, tick, clk_out, running, m_count, m_tick, m_clko, m_run);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_load();
        test_period_change();
        test_period_one();
        test_en_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
